// File: rtl/text_writer.sv
// Character-stream front end for the serial-LCD text buffer: cursor tracking,
// control codes and clear/row-clear sequences. Define TEXT_WRITER_SCROLL_EN to scroll instead of wrapping.
module text_writer #(
    parameter int         TEXT_COLS      = 20,
    parameter int         TEXT_ROWS      = 6,
    parameter int         ADDR_BITS      = 8,
    parameter logic [7:0] FILL_CHAR      = 8'h20,
    parameter logic       CLEAR_ON_RESET = 1'b1
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic [7:0]                   in_char,
    input  logic                         in_char_valid,
    output logic                         out_char_ready,
    output logic [ADDR_BITS-1:0]         out_mem_addr,
    output logic [7:0]                   out_mem_data,
    output logic                         out_mem_write,
    output logic                         out_mem_read,
    input  logic [7:0]                   in_mem_data,
    output logic [$clog2(TEXT_COLS)-1:0] out_cursor_x,
    output logic [$clog2(TEXT_ROWS)-1:0] out_cursor_y,
    output logic                         out_busy,
    output logic [2:0]                   out_dbg_state
);
    localparam int X_W = $clog2(TEXT_COLS);
    localparam int Y_W = $clog2(TEXT_ROWS);
    localparam logic [X_W-1:0]       X_LAST = X_W'(TEXT_COLS - 1);
    localparam logic [Y_W-1:0]       Y_LAST = Y_W'(TEXT_ROWS - 1);
    localparam logic [ADDR_BITS-1:0] COLS_A = ADDR_BITS'(TEXT_COLS);
    localparam logic [ADDR_BITS-1:0] N_A    = ADDR_BITS'(TEXT_COLS * TEXT_ROWS);
    localparam logic [ADDR_BITS-1:0] ONE_A  = ADDR_BITS'(1);
`ifdef TEXT_WRITER_SCROLL_EN
    localparam logic [ADDR_BITS-1:0] ROW_BASE = N_A - COLS_A;
`else
    localparam logic [ADDR_BITS-1:0] ROW_BASE = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_CLEAR, S_ROWCLR
`ifdef TEXT_WRITER_SCROLL_EN
        , S_SCR_RD, S_SCR_WR
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [X_W-1:0]       cx_q, cx_d;
    logic [Y_W-1:0]       cy_q, cy_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 we_q, we_d;
    logic                 adv_q, adv_d;
    logic                 row_adv;
    logic [ADDR_BITS-1:0] cell_addr;
`ifdef TEXT_WRITER_SCROLL_EN
    logic                 re_q, re_d;
    logic                 pass_q, pass_d;
`else
    logic                 unused_mem_data;
    assign unused_mem_data = ^in_mem_data;
`endif

    assign cell_addr = ADDR_BITS'(cy_q) * COLS_A + ADDR_BITS'(cx_q);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            adv_q   <= 1'b0;
`ifdef TEXT_WRITER_SCROLL_EN
            re_q    <= 1'b0;
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            adv_q   <= adv_d;
`ifdef TEXT_WRITER_SCROLL_EN
            re_q    <= re_d;
            pass_q  <= pass_d;
`endif
        end
    end

    // Memory strobes are registered: the state that issues an access runs one cycle ahead of it.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        adv_d   = adv_q;
        row_adv = 1'b0;
`ifdef TEXT_WRITER_SCROLL_EN
        re_d    = 1'b0;
        pass_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_char_valid) begin
                    if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = cell_addr;
                        data_d  = in_char;
                        adv_d   = 1'b1;
                    end else begin
                        case (in_char)
                            8'h0A: begin
                                cx_d    = '0;
                                row_adv = 1'b1;
                            end
                            8'h0D: cx_d = '0;
                            8'h08: begin
                                if (cx_q != '0) begin
                                    cx_d    = cx_q - X_W'(1);
                                    state_d = S_WRITE;
                                    we_d    = 1'b1;
                                    addr_d  = cell_addr - ONE_A;
                                    data_d  = FILL_CHAR;
                                    adv_d   = 1'b0;
                                end
                            end
                            8'h0C: begin
                                cx_d    = '0;
                                cy_d    = '0;
                                cnt_d   = '0;
                                state_d = S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (adv_q) begin
                    if (cx_q == X_LAST) begin
                        cx_d    = '0;
                        row_adv = 1'b1;
                    end else begin
                        cx_d = cx_q + X_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                if (cnt_q != N_A) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = FILL_CHAR;
                    cnt_d  = cnt_q + ONE_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROWCLR: begin
                if (cnt_q != COLS_A) begin
                    we_d   = 1'b1;
                    addr_d = ROW_BASE + cnt_q;
                    data_d = FILL_CHAR;
                    cnt_d  = cnt_q + ONE_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef TEXT_WRITER_SCROLL_EN
            S_SCR_RD: begin
                re_d    = 1'b1;
                addr_d  = cnt_q;
                state_d = S_SCR_WR;
            end
            S_SCR_WR: begin
                we_d   = 1'b1;
                pass_d = 1'b1;
                addr_d = cnt_q - COLS_A;
                if (cnt_q == N_A - ONE_A) begin
                    cnt_d   = '0;
                    state_d = S_ROWCLR;
                end else begin
                    cnt_d   = cnt_q + ONE_A;
                    state_d = S_SCR_RD;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (row_adv) begin
            if (cy_q != Y_LAST) begin
                cy_d = cy_q + Y_W'(1);
            end else begin
`ifdef TEXT_WRITER_SCROLL_EN
                cnt_d   = COLS_A;
                state_d = S_SCR_RD;
`else
                cy_d    = '0;
                cnt_d   = '0;
                state_d = S_ROWCLR;
`endif
            end
        end
    end

    // Handshake: a byte transfers on a rising edge where in_char_valid && out_char_ready; out_char_ready never depends on in_char_valid.
    always_comb begin
        out_char_ready = (state_q == S_IDLE);
        out_busy       = (state_q != S_IDLE) && (state_q != S_WRITE);
        out_mem_addr   = addr_q;
        out_mem_write  = we_q;
        out_cursor_x   = cx_q;
        out_cursor_y   = cy_q;
        out_dbg_state  = state_q;
`ifdef TEXT_WRITER_SCROLL_EN
        out_mem_read   = re_q;
        out_mem_data   = pass_q ? in_mem_data : data_q;
`else
        out_mem_read   = 1'b0;
        out_mem_data   = data_q;
`endif
    end
endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: table of single-byte vectors plus hand-written
// sequences for reset clear, write latency, row wrap/scroll and reset during clear.
module tb_text_writer;
    localparam int COLS = 20;
    localparam int ROWS = 6;
    localparam int N    = COLS * ROWS;
    localparam int W    = 17;

    logic       clk = 1'b0;
    logic       in_rst = 1'b1;
    logic [7:0] in_char = 8'h00;
    logic       in_char_valid = 1'b0;
    logic       out_char_ready;
    logic [7:0] out_mem_addr;
    logic [7:0] out_mem_data;
    logic       out_mem_write;
    logic       out_mem_read;
    logic [7:0] in_mem_data;
    logic [4:0] out_cursor_x;
    logic [2:0] out_cursor_y;
    logic       out_busy;
    logic [2:0] out_dbg_state;

    logic [7:0] mem [0:255];
    logic       preload_req = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_got, mon_exp;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] c;
        int         exp_x;
        int         exp_y;
        bit         has_wr;
        int         wr_addr;
        logic [7:0] wr_data;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    text_writer dut (
        .in_clk(clk), .in_rst(in_rst), .in_char(in_char), .in_char_valid(in_char_valid),
        .out_char_ready(out_char_ready), .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read), .in_mem_data(in_mem_data),
        .out_cursor_x(out_cursor_x), .out_cursor_y(out_cursor_y), .out_busy(out_busy),
        .out_dbg_state(out_dbg_state)
    );

    // Text RAM port 1 with one-cycle read latency.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int a = 0; a < N; a++) mem[a] <= 8'(a / COLS);
        end else if (out_mem_write) begin
            mem[out_mem_addr] <= out_mem_data;
        end
        if (out_mem_read) in_mem_data <= mem[out_mem_addr];
    end

    // Scoreboard: every write strobe is matched against the next expected {busy, addr, data}.
    always @(negedge clk) begin
        if (out_mem_write) begin
            mon_got = {out_busy, out_mem_addr, out_mem_data};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got busy=%0b addr=%0d data=%h, required no write",
                         out_busy, out_mem_addr, out_mem_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                begin
                    n_err++;
                    $display("FAIL write: got busy=%0b addr=%0d data=%h, required busy=%0b addr=%0d data=%h",
                             mon_got[16], mon_got[15:8], mon_got[7:0], mon_exp[16], mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push_wr(input bit busy, input int addr, input logic [7:0] data);
        exp_q.push_back({busy, 8'(addr), data});
    endtask

    task automatic push_clear();
        for (int a = 0; a < N; a++) push_wr(1'b1, a, 8'h20);
    endtask

    task automatic wait_ready(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (out_char_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, required ready=1", max_cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] c);
        wait_ready(400);
        in_char = c;
        in_char_valid = 1'b1;
        @(posedge clk);
        #1 in_char_valid = 1'b0;
    endtask

    task automatic add_vec(input logic [7:0] c, input int x, input int y,
                           input bit has_wr, input int addr, input logic [7:0] data);
        vec_t v;
        v.c = c; v.exp_x = x; v.exp_y = y; v.has_wr = has_wr; v.wr_addr = addr; v.wr_data = data;
        vecs.push_back(v);
    endtask

    initial begin
        int errs;
        bit hit;

        add_vec(8'h42, 2, 0, 1, 1, 8'h42);
        add_vec(8'h0D, 0, 0, 0, 0, 8'h00);
        add_vec(8'h0A, 0, 1, 0, 0, 8'h00);
        add_vec(8'h0A, 0, 2, 0, 0, 8'h00);
        add_vec(8'h01, 0, 2, 0, 0, 8'h00);
        add_vec(8'h7F, 0, 2, 0, 0, 8'h00);
        add_vec(8'h1B, 0, 2, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++)
            add_vec(8'(8'h61 + i), (i + 1) % COLS, (i == 19) ? 3 : 2, 1, 40 + i, 8'(8'h61 + i));
        add_vec(8'h08, 0, 3, 0, 0, 8'h00);
        add_vec(8'h58, 1, 3, 1, 60, 8'h58);
        add_vec(8'h08, 0, 3, 1, 60, 8'h20);
        add_vec(8'h7E, 1, 3, 1, 60, 8'h7E);
        add_vec(8'h0D, 0, 3, 0, 0, 8'h00);
        add_vec(8'h0A, 0, 4, 0, 0, 8'h00);
        add_vec(8'h0A, 0, 5, 0, 0, 8'h00);

        // Reset state and the power-on clear.
        push_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_write", out_mem_write, 0);
        check("rst_read", out_mem_read, 0);
        check("rst_addr", out_mem_addr, 0);
        check("rst_data", out_mem_data, 0);
        check("rst_busy", out_busy, 1);
        check("rst_ready", out_char_ready, 0);
        check("rst_cursor_x", out_cursor_x, 0);
        check("rst_cursor_y", out_cursor_y, 0);
        in_rst = 1'b0;
        wait_ready(300);
        check("clear_pending", exp_q.size(), 0);
        check("clear_cursor_x", out_cursor_x, 0);
        check("clear_cursor_y", out_cursor_y, 0);

        // First printable byte: strobe one cycle after acceptance, ready back the cycle after.
        push_wr(1'b0, 0, 8'h41);
        in_char = 8'h41;
        in_char_valid = 1'b1;
        @(posedge clk);
        #1 in_char_valid = 1'b0;
        check("lat_write", out_mem_write, 1);
        check("lat_ready_low", out_char_ready, 0);
        check("lat_cursor_hold", out_cursor_x, 0);
        @(posedge clk);
        #1;
        check("lat_write_off", out_mem_write, 0);
        check("lat_ready_high", out_char_ready, 1);
        check("lat_cursor_x", out_cursor_x, 1);

        foreach (vecs[i]) begin
            if (vecs[i].has_wr) push_wr(1'b0, vecs[i].wr_addr, vecs[i].wr_data);
            send_byte(vecs[i].c);
            wait_ready(50);
            check($sformatf("vec%0d_x", i), out_cursor_x, vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), out_cursor_y, vecs[i].exp_y);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
        end

`ifdef TEXT_WRITER_SCROLL_EN
        @(negedge clk);
        preload_req = 1'b1;
        @(posedge clk);
        #1 preload_req = 1'b0;
        for (int a = COLS; a < N; a++) push_wr(1'b1, a - COLS, 8'(a / COLS));
        for (int a = N - COLS; a < N; a++) push_wr(1'b1, a, 8'h20);
        send_byte(8'h0A);
        wait_ready(400);
        check("scroll_pending", exp_q.size(), 0);
        check("scroll_cursor_x", out_cursor_x, 0);
        check("scroll_cursor_y", out_cursor_y, 5);
        for (int r = 0; r < ROWS; r++) begin
            errs = 0;
            for (int c = 0; c < COLS; c++)
                if (mem[r * COLS + c] !== ((r == ROWS - 1) ? 8'h20 : 8'(r + 1))) errs++;
            check($sformatf("scroll_row%0d_bad_cells", r), errs, 0);
        end
`else
        for (int a = 0; a < COLS; a++) push_wr(1'b1, a, 8'h20);
        send_byte(8'h0A);
        wait_ready(100);
        check("wrap_pending", exp_q.size(), 0);
        check("wrap_cursor_x", out_cursor_x, 0);
        check("wrap_cursor_y", out_cursor_y, 0);
        check("wrap_keep_row2", mem[40], 8'h61);
        check("wrap_keep_row3", mem[60], 8'h7E);
`endif

        // Form feed, then reset in the middle of the clear with a byte held on the input.
        for (int a = 0; a <= 50; a++) push_wr(1'b1, a, 8'h20);
        send_byte(8'h0C);
        check("ff_cursor_x", out_cursor_x, 0);
        check("ff_cursor_y", out_cursor_y, 0);
        check("ff_busy", out_busy, 1);
        in_char = 8'h5A;
        in_char_valid = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_mem_write && out_mem_addr == 8'd50) begin
                hit = 1'b1;
                break;
            end
        end
        check("midclear_reached_50", hit, 1);
        in_rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_write", out_mem_write, 0);
        check("midrst_cursor_x", out_cursor_x, 0);
        check("midrst_busy", out_busy, 1);
        check("midrst_ready", out_char_ready, 0);
        check("midrst_pending", exp_q.size(), 0);
        in_rst = 1'b0;
        push_clear();
        push_wr(1'b0, 0, 8'h5A);
        wait_ready(300);
        @(posedge clk);
        #1 in_char_valid = 1'b0;
        wait_ready(50);
        check("held_byte_pending", exp_q.size(), 0);
        check("held_byte_cursor_x", out_cursor_x, 1);
        check("held_byte_cursor_y", out_cursor_y, 0);
        check("final_cell0", mem[0], 8'h5A);
        check("final_cell119", mem[119], 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
